if_id_stage: RTL and testbench

Two-entry skid-buffered pipeline register between instruction fetch and decode in the RV32 core. It captures each fetched instruction with its PC and presents it to decode through a valid/ready handshake. A decode stall never drops or duplicates an instruction, and a fetch-side flush on branch redirect kills everything in flight. Empty slots present the canonical NOP so decode always sees a legal instruction.

---
 rtl/rv_core_pkg.sv | 15 +
 rtl/if_id_stage.sv | 74 +++++++
 tb/tb_if_id_stage.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/rv_core_pkg.sv
// Shared RV32 core types: canonical NOP, IF/ID occupancy states, fetch packet.
package rv_core_pkg;
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } if_id_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;
endpackage

// File: rtl/if_id_stage.sv
// Two-entry skid-buffered IF/ID register: main slot feeds decode, skid slot
// absorbs the one in-flight fetch when decode stalls.
module if_id_stage
  import rv_core_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = RV_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc_plus4
);
  if_id_state_t state, state_nxt;
  fetch_pkt_t   main_q, main_nxt, skid_q, skid_nxt;
  fetch_pkt_t   in_pkt;
  logic         acc, pop;

  assign in_pkt = '{pc: in_pc, instr: in_instr};
  assign acc    = in_valid && in_ready && !flush;
  assign pop    = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    unique case (state)
      EMPTY: if (acc) begin
        state_nxt = ONE;
        main_nxt  = in_pkt;
      end
      ONE: begin
        if (acc && pop) main_nxt = in_pkt;
        else if (acc) begin
          state_nxt = FULL;
          skid_nxt  = in_pkt;
        end else if (pop) state_nxt = EMPTY;
      end
      FULL: if (pop) begin
        state_nxt = ONE;
        main_nxt  = skid_q;
      end
      default: state_nxt = EMPTY;
    endcase
    // Payloads are left as-is on flush so out_pc keeps its last value.
    if (flush) state_nxt = EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      main_q   <= main_nxt;
      skid_q   <= skid_nxt;
      in_ready <= (state_nxt != FULL);
    end
  end

  assign out_valid    = (state != EMPTY);
  assign out_pc       = main_q.pc;
  assign out_instr    = out_valid ? main_q.instr : NOP_INSTR;
  assign out_pc_plus4 = main_q.pc + 32'd4;
endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: streaming, stall/skid, flush, wrap, async reset.
module tb_if_id_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, flush = 1'b0;
  logic [31:0] in_pc = '0, in_instr = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_pc, out_instr, out_pc_plus4;

  int checks = 0;
  int errors = 0;
  logic [31:0] popped[$];
  logic [31:0] tbl [4] = '{32'h12345678, 32'h9abcdef0, 32'h0fedcba9, 32'h87654321};

  localparam logic [31:0] NOP = 32'h0000_0013;

  if_id_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_pc_plus4(out_pc_plus4)
  );

  always #5 clk = ~clk;

  // Record every completed decode handshake.
  always @(posedge clk)
    if (!rst && out_valid && out_ready) popped.push_back(out_pc);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] instr);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr;
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_pc", out_pc, 0);
    chk("rst_instr", out_instr, NOP);
    chk("rst_plus4", out_pc_plus4, 4);
    rst = 1'b0;

    // Streaming with decode always ready
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(32'(4 * i), tbl[i]);
      step();
      chk("strm_valid", 32'(out_valid), 1);
      chk("strm_pc", out_pc, 32'(4 * i));
      chk("strm_instr", out_instr, tbl[i]);
      chk("strm_plus4", out_pc_plus4, 32'(4 * i + 4));
      chk("strm_ready", 32'(in_ready), 1);
    end
    in_valid = 1'b0;
    step();
    chk("strm_empty", 32'(out_valid), 0);
    chk("strm_nop", out_instr, NOP);
    chk("strm_cnt", 32'(popped.size()), 4);
    for (int i = 0; i < 4; i++) chk("strm_ord", popped[i], 32'(4 * i));
    popped.delete();

    // Stall: PC0 presented, PC4 skidded, PC8 held by fetch
    out_ready = 1'b0;
    offer(32'h0, 32'hA0);
    step();
    chk("stl_rdy1", 32'(in_ready), 1);
    offer(32'h4, 32'hA4);
    step();
    chk("stl_full_rdy", 32'(in_ready), 0);
    chk("stl_pc0", out_pc, 32'h0);
    offer(32'h8, 32'hA8);
    step();
    chk("stl_hold_rdy", 32'(in_ready), 0);
    chk("stl_hold_pc", out_pc, 32'h0);
    chk("stl_hold_ins", out_instr, 32'hA0);
    out_ready = 1'b1;
    step();
    chk("stl_pc4", out_pc, 32'h4);
    chk("stl_ins4", out_instr, 32'hA4);
    chk("stl_rdy_back", 32'(in_ready), 1);
    step();
    chk("stl_pc8", out_pc, 32'h8);
    in_valid = 1'b0;
    step();
    chk("stl_empty", 32'(out_valid), 0);
    chk("stl_cnt", 32'(popped.size()), 3);
    for (int i = 0; i < 3; i++) chk("stl_ord", popped[i], 32'(4 * i));
    popped.delete();

    // Flush while FULL with a same-cycle offer
    out_ready = 1'b0;
    offer(32'h10, 32'hB0);
    step();
    offer(32'h14, 32'hB4);
    step();
    chk("fl_full", 32'(in_ready), 0);
    offer(32'h40, 32'hC0);
    flush = 1'b1;
    step();
    chk("fl_valid", 32'(out_valid), 0);
    chk("fl_nop", out_instr, NOP);
    chk("fl_ready", 32'(in_ready), 1);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("fl_no40", 32'(out_valid), 0);
    chk("fl_cnt", 32'(popped.size()), 0);

    // Flush coinciding with pop; same-cycle offer is discarded
    out_ready = 1'b0;
    offer(32'h20, 32'hD0);
    step();
    out_ready = 1'b1;
    flush = 1'b1;
    offer(32'h24, 32'hD4);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flp_empty", 32'(out_valid), 0);
    step();
    chk("flp_still", 32'(out_valid), 0);
    chk("flp_cnt", 32'(popped.size()), 1);
    chk("flp_pc", popped[0], 32'h20);
    popped.delete();

    // PC+4 wrap
    out_ready = 1'b0;
    offer(32'hFFFF_FFFC, 32'hDEADBEEF);
    step();
    chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", out_pc_plus4, 32'h0);
    chk("wrap_instr", out_instr, 32'hDEADBEEF);

    // Async reset while FULL, checked before the next edge
    offer(32'h100, 32'hE0);
    step();
    chk("ar_full", 32'(in_ready), 0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 0);
    chk("ar_ready", 32'(in_ready), 1);
    chk("ar_pc", out_pc, 0);
    chk("ar_instr", out_instr, NOP);
    chk("ar_plus4", out_pc_plus4, 4);
    out_ready = 1'b1;
    step();
    rst = 1'b0;
    offer(32'h200, 32'h00500093);
    step();
    chk("ar_res_pc", out_pc, 32'h200);
    chk("ar_res_ins", out_instr, 32'h00500093);
    in_valid = 1'b0;
    step();
    chk("ar_res_empty", 32'(out_valid), 0);
    chk("ar_cnt", 32'(popped.size()), 1);
    chk("ar_pop", popped[0], 32'h200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
